// File: rtl/mdu_ctrl.sv
// ---------------------------------------------------------------------------
// mdu_ctrl -- multiply/divide unit controller for the E stage.
//
// Starts a mult/multu/div/divu, holds the computed result as pending while
// the unit stays busy for a fixed number of cycles, then commits it to HI/LO.
// mthi/mtlo write HI/LO directly while idle. mfhi/mflo read HI/LO
// combinationally on MD_Out.
//
// Parameters
//   MULT_CYCLES  busy cycles for mult/multu after the start cycle
//   DIV_CYCLES   busy cycles for div/divu after the start cycle
//
// Ports
//   clk        clock, rising edge
//   reset      asynchronous active-low reset
//   E_MDOp     E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu,
//              5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9-15 none
//   E_A, E_B   rs / rt operands after forwarding
//   D_MDUse    D-stage instruction is an MDU op
//   Busy       a mult/div is in flight
//   Stall_MD   stall request to the hazard unit
//   HI, LO     committed HI/LO registers
//   MD_Out     HI for mfhi, LO for mflo, otherwise 0
//   dbg_state  current FSM state (0 IDLE, 1 BUSY)
//
// Optional feature: define MDU_DIVZERO_KEEP_EN to make a divide by zero a
// no-op (no busy period, HI/LO untouched). Without it, a divide by zero
// runs the full divide latency and commits HI=E_A, LO=0xFFFFFFFF.
// ---------------------------------------------------------------------------
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_MDOp,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        D_MDUse,
  output logic        Busy,
  output logic        Stall_MD,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MD_Out,
  output logic        dbg_state
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t        state, next_state;
  logic [CW-1:0] cnt;
  logic [31:0]   pend_hi, pend_lo;

  logic          is_mul, is_div, start, go, div_zero, commit;
  logic [31:0]   res_hi, res_lo;
  logic [63:0]   prod;
  logic          a_neg, b_neg;
  logic [31:0]   ua, ub, uq, ur, b_safe;

  // Operation decode and start condition. Start is gated by reset so that
  // no stall is requested while the block is held in reset.
  always_comb begin
    is_mul   = (E_MDOp == 4'd1) || (E_MDOp == 4'd2);
    is_div   = (E_MDOp == 4'd3) || (E_MDOp == 4'd4);
    start    = reset && (is_mul || is_div) && (state == IDLE);
    div_zero = is_div && (E_B == 32'd0);
`ifdef MDU_DIVZERO_KEEP_EN
    go       = start && !div_zero;
`else
    go       = start;
`endif
    commit   = (state == BUSY) && (cnt <= CW'(1));
  end

  // Result datapath. Signed divide works on magnitudes, then restores signs:
  // quotient negative when operand signs differ, remainder takes the
  // dividend's sign. This also makes 0x80000000 / -1 come out as 0x80000000
  // with remainder 0 without relying on signed-overflow behaviour.
  always_comb begin
    prod   = 64'd0;
    res_hi = 32'd0;
    res_lo = 32'd0;
    a_neg  = (E_MDOp == 4'd3) && E_A[31];
    b_neg  = (E_MDOp == 4'd3) && E_B[31];
    ua     = a_neg ? (32'd0 - E_A) : E_A;
    ub     = b_neg ? (32'd0 - E_B) : E_B;
    b_safe = (ub == 32'd0) ? 32'd1 : ub;
    uq     = ua / b_safe;
    ur     = ua % b_safe;
    case (E_MDOp)
      4'd1: begin
        // Sign-extended 64-bit product: the low 64 bits equal the signed product.
        prod   = {{32{E_A[31]}}, E_A} * {{32{E_B[31]}}, E_B};
        res_hi = prod[63:32];
        res_lo = prod[31:0];
      end
      4'd2: begin
        prod   = {32'd0, E_A} * {32'd0, E_B};
        res_hi = prod[63:32];
        res_lo = prod[31:0];
      end
      4'd3, 4'd4: begin
        if (div_zero) begin
          res_hi = E_A;
          res_lo = 32'hFFFF_FFFF;
        end else begin
          res_lo = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
          res_hi = a_neg ? (32'd0 - ur) : ur;
        end
      end
      default: begin
        res_hi = 32'd0;
        res_lo = 32'd0;
      end
    endcase
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (go) next_state = BUSY;
      BUSY:    if (commit) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      HI      <= 32'd0;
      LO      <= 32'd0;
    end else begin
      state <= next_state;
      if (go) begin
        cnt     <= is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        pend_hi <= res_hi;
        pend_lo <= res_lo;
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end

      if (commit) begin
        HI <= pend_hi;
        LO <= pend_lo;
      end else if (state == IDLE) begin
        if (E_MDOp == 4'd7) HI <= E_A;
        if (E_MDOp == 4'd8) LO <= E_A;
      end
    end
  end

  always_comb begin
    Busy      = (state == BUSY);
    Stall_MD  = D_MDUse && (start || Busy);
    dbg_state = state;
    case (E_MDOp)
      4'd5:    MD_Out = HI;
      4'd6:    MD_Out = LO;
      default: MD_Out = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mdu_ctrl -- directed self-checking bench for mdu_ctrl.
// Inputs change 1 time unit after a rising edge; outputs are checked after
// a further settle delay, well before the next rising edge.
// ---------------------------------------------------------------------------
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  E_MDOp;
  logic [31:0] E_A, E_B;
  logic        D_MDUse;
  logic        Busy, Stall_MD, dbg_state;
  logic [31:0] HI, LO, MD_Out;

  int compared = 0;
  int mismatched = 0;
  int n;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .E_MDOp    (E_MDOp),
    .E_A       (E_A),
    .E_B       (E_B),
    .D_MDUse   (D_MDUse),
    .Busy      (Busy),
    .Stall_MD  (Stall_MD),
    .HI        (HI),
    .LO        (LO),
    .MD_Out    (MD_Out),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a mult/div for one cycle, then count busy cycles until commit.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int cycles);
    E_MDOp = op;
    E_A    = a;
    E_B    = b;
    step();
    E_MDOp = 4'd0;
    cycles = 0;
    while (Busy === 1'b1 && cycles < 100) begin
      cycles++;
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b0;
    E_MDOp  = 4'd1;
    E_A     = 32'd7;
    E_B     = 32'd3;
    D_MDUse = 1'b1;

    // Reset state: no stall even with a mult in E and an MDU op in D.
    #3;
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_stall", {31'd0, Stall_MD}, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    E_MDOp = 4'd5;
    #1;
    chk("rst_mdout", MD_Out, 32'd0);
    step();
    step();
    reset   = 1'b1;
    E_MDOp  = 4'd0;
    D_MDUse = 1'b0;
    #1;
    chk("idle_state", {31'd0, dbg_state}, 32'd0);

    // mthi / mtlo then mfhi / mflo with no added latency.
    E_MDOp = 4'd7; E_A = 32'h1234_5678;
    step();
    E_MDOp = 4'd5;
    #1;
    chk("mfhi", MD_Out, 32'h1234_5678);
    E_MDOp = 4'd8; E_A = 32'hCAFE_F00D;
    step();
    E_MDOp = 4'd6;
    #1;
    chk("mflo", MD_Out, 32'hCAFE_F00D);

    // mult -2 * 3: five busy cycles, HI/LO hold old values meanwhile.
    E_MDOp = 4'd1; E_A = 32'hFFFF_FFFE; E_B = 32'd3; D_MDUse = 1'b1;
    #1;
    chk("mult_start_stall", {31'd0, Stall_MD}, 32'd1);
    step();
    E_MDOp = 4'd0; D_MDUse = 1'b0;
    #1;
    chk("mult_hold_hi", HI, 32'h1234_5678);
    chk("mult_hold_lo", LO, 32'hCAFE_F00D);
    n = 0;
    while (Busy === 1'b1 && n < 100) begin
      n++;
      step();
    end
    chk("mult_busy_cycles", n, 32'd5);
    chk("mult_hi", HI, 32'hFFFF_FFFF);
    chk("mult_lo", LO, 32'hFFFF_FFFA);

    // divu 17/5 with mflo waiting in D: stall for start + 10 busy cycles.
    E_MDOp = 4'd4; E_A = 32'd17; E_B = 32'd5; D_MDUse = 1'b1;
    #1;
    n = 0;
    while (Stall_MD === 1'b1 && n < 100) begin
      n++;
      step();
      E_MDOp = 4'd0;
      #1;
    end
    chk("divu_stall_cycles", n, 32'd11);
    E_MDOp = 4'd6;
    #1;
    chk("divu_lo", MD_Out, 32'd3);
    E_MDOp = 4'd5;
    #1;
    chk("divu_hi", MD_Out, 32'd2);
    D_MDUse = 1'b0;

    // Signed divides: truncation toward zero, and the overflow corner.
    run_op(4'd3, 32'hFFFF_FFF9, 32'd2, n);
    chk("div_cycles", n, 32'd10);
    chk("div_neg_lo", LO, 32'hFFFF_FFFD);
    chk("div_neg_hi", HI, 32'hFFFF_FFFF);
    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, n);
    chk("div_ovf_lo", LO, 32'h8000_0000);
    chk("div_ovf_hi", HI, 32'd0);

    // A second mult presented while busy must not reload the counter.
    E_MDOp = 4'd1; E_A = 32'd2; E_B = 32'd3;
    step();
    E_A = 32'd5; E_B = 32'd5;
    n = 0;
    while (Busy === 1'b1 && n < 100) begin
      n++;
      if (n == 3) E_MDOp = 4'd0;
      step();
    end
    chk("noreload_cycles", n, 32'd5);
    chk("noreload_lo", LO, 32'd6);
    chk("noreload_hi", HI, 32'd0);

    // Reset in the 3rd busy cycle of multu: abort, no commit.
    E_MDOp = 4'd2; E_A = 32'hFFFF_FFFF; E_B = 32'd2;
    step();
    E_MDOp = 4'd0;
    step();
    step();
    #2;
    reset = 1'b0;
    #1;
    chk("abort_busy", {31'd0, Busy}, 32'd0);
    chk("abort_lo", LO, 32'd0);
    step();
    reset = 1'b1;
    repeat (12) step();
    chk("abort_busy_after", {31'd0, Busy}, 32'd0);
    chk("abort_hi_after", HI, 32'd0);
    chk("abort_lo_after", LO, 32'd0);

    // Divide by zero with HI=1, LO=2 beforehand.
    E_MDOp = 4'd7; E_A = 32'd1;
    step();
    E_MDOp = 4'd8; E_A = 32'd2;
    step();
    E_MDOp = 4'd4; E_A = 32'd9; E_B = 32'd0; D_MDUse = 1'b1;
    #1;
    chk("divz_start_stall", {31'd0, Stall_MD}, 32'd1);
    step();
    E_MDOp = 4'd0; D_MDUse = 1'b0;
    n = 0;
    while (Busy === 1'b1 && n < 100) begin
      n++;
      step();
    end
`ifdef MDU_DIVZERO_KEEP_EN
    chk("divz_cycles", n, 32'd0);
    chk("divz_hi", HI, 32'd1);
    chk("divz_lo", LO, 32'd2);
`else
    chk("divz_cycles", n, 32'd10);
    chk("divz_hi", HI, 32'd9);
    chk("divz_lo", LO, 32'hFFFF_FFFF);
`endif

    // Reserved op codes behave as none.
    E_MDOp = 4'd12; E_A = 32'h55; E_B = 32'd3; D_MDUse = 1'b1;
    #1;
    chk("rsv_stall", {31'd0, Stall_MD}, 32'd0);
    chk("rsv_mdout", MD_Out, 32'd0);
    step();
    chk("rsv_busy", {31'd0, Busy}, 32'd0);
    E_MDOp = 4'd0; D_MDUse = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
